osc_clk_div_gen: RTL and testbench
==================================

Name: osc_clk_div_gen

Overview:
Parametrised clock-enable and divided-clock generator fed by the on-chip RC oscillator domain (50 MHz on PCLK). It replaces the bare oscillator instance with a block that gates all outputs behind an oscillator-settle interval. It then produces NUM_CH independently programmable tick strobes and 50%-duty divided clocks, for example the SCCB SCL bit-rate tick and the camera XCLK. Divider values come from APB-side configuration registers in the SCCB wrapper.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 16, width of each channel's divider value and counter.
- STARTUP_CYCLES, 1024, PCLK cycles after reset release before osc_ready asserts (>=1).

Ports:
- PCLK  input  1  system clock, RC oscillator derived.
- PRESETN  input  1  asynchronous active-low reset.
- div_val  input  NUM_CH*CNT_W  per-channel divide value; channel i uses bits [i*CNT_W +: CNT_W].
- ch_en  input  NUM_CH  per-channel enable.
- osc_ready  output  1  high once the startup interval has expired; stays high until reset.
- tick_o  output  NUM_CH  one-PCLK-cycle pulse per channel period.
- clk_o  output  NUM_CH  registered divided clock per channel.
- busy_o  output  NUM_CH  channel running (enabled and ready).

Behaviour:
- Reset: the clock is single and the reset is asynchronous, active-low (PCLK, PRESETN).
- Outputs at reset:
  - osc_ready=0, tick_o=0, clk_o=0, busy_o=0.
  - All counters = 0; all shadow registers = 0.
- Startup counter:
  - Counts from 0 after PRESETN deasserts.
  - osc_ready goes high on the cycle after the count reaches STARTUP_CYCLES-1.
  - The counter then saturates, with no wrap.
- Channel state, per channel, 2 states:
  - IDLE to RUN when ch_en[i]=1 and osc_ready=1. On entry, the counter is set to 0 and shadow is loaded from div_val.
  - RUN to IDLE when ch_en[i]=0. The counter clears, clk_o is forced to 0 on the next edge, and tick_o is forced to 0.
  - busy_o[i] is high in RUN.
- In RUN:
  - The counter increments each cycle.
  - When counter == shadow, it returns to 0 and tick_o[i] pulses for 1 cycle (registered, visible the next cycle).
  - clk_o[i] toggles on the same edge as the tick pulse.
  - Tick period = shadow+1 cycles; clk_o period = 2*(shadow+1) cycles.
- shadow=0: tick_o is high every cycle and clk_o = PCLK/2.
- div_val changes mid-count are ignored until terminal count. shadow reloads only at counter==shadow, so there are no short or runt periods.
- First tick after entering RUN arrives shadow+1 cycles after entry.
- Simultaneous ch_en fall and terminal count: disable wins. No tick is emitted and clk_o becomes 0.
- Counter width is CNT_W, unsigned, and cannot overflow, because the counter is reset at ==shadow and shadow <= 2^CNT_W-1.
- PRESETN assertion mid-operation: all outputs return to reset values immediately (asynchronous). The startup interval restarts after release.
- Channels are fully independent apart from the shared osc_ready gate.

Optional Feature:
Macro: OSC_CLK_DIV_PHASE_ALIGN_EN.
- Defined:
  - Adds an input port sync_i (1 bit).
  - A cycle with sync_i=1 clears every RUN channel's counter to 0, sets clk_o to 0, reloads shadow from div_val, and suppresses that cycle's tick.
  - This phase-aligns all channels.
  - sync_i wins over terminal count and loses to ch_en=0.
- Undefined:
  - No sync_i port.
  - Channels free-run with independent phase set only by their enable time.

Decomposition:
- Shared package osc_clk_pkg holds:
  - the channel state enum (CH_IDLE, CH_RUN);
  - a default STARTUP_CYCLES constant;
  - a function returning the startup counter width via clog2.
- One natural sub-module, osc_clk_div_ch: a single channel containing counter, shadow, state, tick and clk.
- The top level holds the startup counter and a generate loop of NUM_CH channel instances.

Test Plan:
- Reset release, STARTUP_CYCLES=16, ch_en=all 1 -> osc_ready rises 16 cycles after release; no tick_o and clk_o stays 0 before that.
- Ch0 div_val=4 -> tick_o[0] every 5 cycles; clk_o[0] period 10 cycles, 50% duty. Ch1 div_val=0 -> tick_o[1] constant 1 and clk_o[1]=PCLK/2.
- Ch0 div_val changed 4 to 9 at counter=2 -> current period completes at 5 cycles; subsequent ticks every 10 cycles; no runt pulse.
- ch_en[0] dropped on the terminal-count cycle -> no tick, clk_o[0]=0 next cycle, busy_o[0]=0. Re-enable -> first tick after div_val+1 cycles.
- PRESETN pulsed low mid-run -> all outputs 0 asynchronously; osc_ready is re-delayed by STARTUP_CYCLES.
- With OSC_CLK_DIV_PHASE_ALIGN_EN: ch0 div=3, ch1 div=7, sync_i pulse -> both counters zero. Thereafter every 2nd ch0 tick coincides with a ch1 tick.

Source files
------------

// File: rtl/osc_clk_pkg.sv
// Shared types and constants for the oscillator clock-divider block.
// Holds the channel state encoding and startup-counter sizing helper.
package osc_clk_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    localparam int DEF_STARTUP_CYCLES = 1024;

    function automatic int startup_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/osc_clk_div_ch.sv
// One divider channel: shadowed divide value, counter, tick and clock.
// Shadow reloads only at terminal count so no runt periods occur.
module osc_clk_div_ch
    import osc_clk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] div_val,
    input  logic             en,
    input  logic             ready,
    input  logic             sync,
    output logic             tick_o,
    output logic             clk_o,
    output logic             busy_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             tick_d, clk_d;

    // Next-state: disable beats sync, sync beats terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        tick_d  = 1'b0;
        clk_d   = clk_o;
        unique case (state_q)
            CH_IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (en && ready) begin
                    state_d = CH_RUN;
                    shd_d   = div_val;
                end
            end
            CH_RUN: begin
                if (!en) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else if (sync) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    shd_d = div_val;
                end else if (cnt_q == shd_q) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    clk_d  = ~clk_o;
                    shd_d  = div_val;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // Channel state, counter, shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            shd_q   <= '0;
            tick_o  <= 1'b0;
            clk_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shd_q   <= shd_d;
            tick_o  <= tick_d;
            clk_o   <= clk_d;
        end
    end

    assign busy_o = (state_q == CH_RUN);

endmodule

// File: rtl/osc_clk_div_gen.sv
// Oscillator settle gate plus NUM_CH tick/divided-clock channels.
// Optional OSC_CLK_DIV_PHASE_ALIGN_EN adds sync_i to phase-align channels.
module osc_clk_div_gen
    import osc_clk_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 16,
    parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES
) (
    input  logic                    PCLK,
    input  logic                    PRESETN,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       ch_en,
`ifdef OSC_CLK_DIV_PHASE_ALIGN_EN
    input  logic                    sync_i,
`endif
    output logic                    osc_ready,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       busy_o
);

    localparam int SW = startup_cnt_w(STARTUP_CYCLES);
    localparam logic [SW-1:0] S_LAST = SW'(STARTUP_CYCLES - 1);

    logic [SW-1:0] su_cnt;
    logic          sync;

`ifdef OSC_CLK_DIV_PHASE_ALIGN_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    // Settle counter saturates at the last count; ready follows a cycle later.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            su_cnt    <= '0;
            osc_ready <= 1'b0;
        end else begin
            if (su_cnt != S_LAST) su_cnt <= su_cnt + 1'b1;
            osc_ready <= (su_cnt == S_LAST);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        osc_clk_div_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (PCLK),
            .rst_n   (PRESETN),
            .div_val (div_val[i*CNT_W +: CNT_W]),
            .en      (ch_en[i]),
            .ready   (osc_ready),
            .sync    (sync),
            .tick_o  (tick_o[i]),
            .clk_o   (clk_o[i]),
            .busy_o  (busy_o[i])
        );
    end

endmodule

// File: tb/tb_osc_clk_div_gen.sv
// Directed bench for osc_clk_div_gen with STARTUP_CYCLES=16, two channels.
// Outputs are sampled on the falling edge of PCLK.
module tb_osc_clk_div_gen;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic [31:0] div_val;
    logic [1:0]  ch_en;
    logic        sync_i;
    logic        osc_ready;
    logic [1:0]  tick_o;
    logic [1:0]  clk_o;
    logic [1:0]  busy_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 PCLK = ~PCLK;

    osc_clk_div_gen #(
        .NUM_CH         (2),
        .CNT_W          (16),
        .STARTUP_CYCLES (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .div_val   (div_val),
        .ch_en     (ch_en),
`ifdef OSC_CLK_DIV_PHASE_ALIGN_EN
        .sync_i    (sync_i),
`endif
        .osc_ready (osc_ready),
        .tick_o    (tick_o),
        .clk_o     (clk_o),
        .busy_o    (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge PCLK);
        cyc++;
    endtask

    initial begin
        logic e_t0, e_c0, e_c1;
        PRESETN = 1'b0;
        ch_en   = 2'b11;
        div_val = {16'd0, 16'd4};
        sync_i  = 1'b0;
        repeat (2) @(negedge PCLK);
        check("rst_ready", 32'(osc_ready), 0);
        check("rst_tick", 32'(tick_o), 0);
        check("rst_clk", 32'(clk_o), 0);
        check("rst_busy", 32'(busy_o), 0);

        PRESETN = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 15; k++) begin
            nxt();
            check("startup_ready", 32'(osc_ready), 0);
            check("startup_tick", 32'(tick_o), 0);
            check("startup_clk", 32'(clk_o), 0);
            check("startup_busy", 32'(busy_o), 0);
        end
        nxt();
        check("ready_rise", 32'(osc_ready), 1);
        check("ready_busy", 32'(busy_o), 0);
        nxt();
        check("entry_busy", 32'(busy_o), 2'b11);
        check("entry_tick", 32'(tick_o), 0);
        check("entry_clk", 32'(clk_o), 0);

        for (int k = 18; k <= 44; k++) begin
            nxt();
            e_t0 = ((cyc - 17) % 5) == 0;
            e_c0 = (((cyc - 17) / 5) % 2) == 1;
            e_c1 = ((cyc - 17) % 2) == 1;
            check("div4_tick0", 32'(tick_o[0]), 32'(e_t0));
            check("div4_clk0", 32'(clk_o[0]), 32'(e_c0));
            check("div0_tick1", 32'(tick_o[1]), 1);
            check("div0_clk1", 32'(clk_o[1]), 32'(e_c1));
        end

        div_val[15:0] = 16'd9;
        for (int k = 45; k <= 76; k++) begin
            nxt();
            e_t0 = (cyc == 47) || (cyc == 57) || (cyc == 67);
            e_c0 = (cyc < 47) || ((cyc >= 57) && (cyc < 67));
            e_c1 = ((cyc - 17) % 2) == 1;
            check("reload_tick0", 32'(tick_o[0]), 32'(e_t0));
            check("reload_clk0", 32'(clk_o[0]), 32'(e_c0));
            check("reload_tick1", 32'(tick_o[1]), 1);
            check("reload_clk1", 32'(clk_o[1]), 32'(e_c1));
        end

        ch_en = 2'b10;
        nxt();
        check("dis_tick0", 32'(tick_o[0]), 0);
        check("dis_clk0", 32'(clk_o[0]), 0);
        check("dis_busy", 32'(busy_o), 2'b10);
        check("dis_tick1", 32'(tick_o[1]), 1);
        nxt();
        check("idle_busy0", 32'(busy_o[0]), 0);
        ch_en = 2'b11;
        nxt();
        check("reen_busy", 32'(busy_o), 2'b11);
        check("reen_tick0", 32'(tick_o[0]), 0);
        check("reen_clk0", 32'(clk_o[0]), 0);
        for (int k = 80; k <= 88; k++) begin
            nxt();
            check("reen_wait_tick0", 32'(tick_o[0]), 0);
        end
        nxt();
        check("reen_first_tick0", 32'(tick_o[0]), 1);
        check("reen_first_clk0", 32'(clk_o[0]), 1);

        #2 PRESETN = 1'b0;
        #1;
        check("async_ready", 32'(osc_ready), 0);
        check("async_tick", 32'(tick_o), 0);
        check("async_clk", 32'(clk_o), 0);
        check("async_busy", 32'(busy_o), 0);

        div_val = {16'd7, 16'd3};
        @(negedge PCLK);
        PRESETN = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 15; k++) begin
            nxt();
            check("restart_ready", 32'(osc_ready), 0);
            check("restart_busy", 32'(busy_o), 0);
        end
        nxt();
        check("restart_rise", 32'(osc_ready), 1);

`ifdef OSC_CLK_DIV_PHASE_ALIGN_EN
        for (int k = 17; k <= 20; k++) nxt();
        sync_i = 1'b1;
        nxt();
        sync_i = 1'b0;
        check("sync_tick", 32'(tick_o), 0);
        check("sync_clk", 32'(clk_o), 0);
        for (int k = 22; k <= 40; k++) begin
            nxt();
            check("align_tick0", 32'(tick_o[0]),
                  32'(((cyc - 21) % 4) == 0));
            check("align_tick1", 32'(tick_o[1]),
                  32'(((cyc - 21) % 8) == 0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
